// File: rtl/adc_offset_cutter_pkg.sv
// Shared definitions for the ADC offset cutter: calibration FSM states
// and default geometry of the sample path.
package adc_offset_cutter_pkg;

    typedef enum logic {
        OFS_IDLE = 1'b0,
        OFS_CAL  = 1'b1
    } ofs_state_t;

    localparam int DEF_WIDTH    = 14;
    localparam int DEF_CAL_LOG2 = 8;

endpackage

// File: rtl/adc_offset_cutter_calibrator.sv
// On-chip offset calibration: averages 2^CAL_LOG2 accepted samples and
// publishes the truncated mean as the calibrated offset.
module offset_calibrator
    import adc_offset_cutter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CAL_LOG2 = DEF_CAL_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic             i_accept,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_offset
);

    localparam int AW = WIDTH + CAL_LOG2;

    ofs_state_t            r_state;
    ofs_state_t            w_next;
    logic [AW-1:0]         r_acc;
    logic [CAL_LOG2-1:0]   r_cnt;
    logic                  r_done;
    logic [WIDTH-1:0]      r_offset;
    logic [AW-1:0]         w_sum;
    logic [WIDTH-1:0]      w_avg;
    logic                  w_add;
    logic                  w_last;

    assign w_add  = (r_state == OFS_CAL) && i_accept && !i_clear;
    assign w_last = w_add && (&r_cnt);
    assign w_sum  = r_acc + {{CAL_LOG2{1'b0}}, i_data};
    assign w_avg  = WIDTH'(w_sum >> CAL_LOG2);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            OFS_IDLE: if (i_start) w_next = OFS_CAL;
            OFS_CAL:  if (w_last)  w_next = OFS_IDLE;
            default:  w_next = OFS_IDLE;
        endcase
        if (i_clear) w_next = OFS_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= OFS_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_offset <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (i_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == OFS_IDLE && i_start) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_add) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CAL_LOG2'(1);
                if (w_last) begin
                    r_offset <= w_avg;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_busy   = (r_state == OFS_CAL);
    assign o_done   = r_done;
    assign o_offset = r_offset;

endmodule

// File: rtl/adc_offset_cutter.sv
// Removes the DC offset from the unsigned ADC stream and emits a signed
// stream; offset is manual or calibrated on-chip.
module adc_offset_cutter
    import adc_offset_cutter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CAL_LOG2 = DEF_CAL_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH:0]   o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    input  logic [WIDTH-1:0] offset_in,
    input  logic             offset_sel,
    input  logic             cal_start,
    output logic             cal_busy,
    output logic             cal_done,
    output logic [WIDTH-1:0] cal_offset
);

    logic             r_tvalid;
    logic [WIDTH:0]   r_tdata;
    logic             w_accept;
    logic [WIDTH-1:0] w_off;
    logic [WIDTH:0]   w_diff;

    assign i_tready = !r_tvalid || o_tready;
    assign w_accept = i_tvalid && i_tready && !clear;

    // The calibrated offset only moves on the edge after the final
    // calibration sample, so that sample is still cut with the old one.
    assign w_off  = offset_sel ? cal_offset : offset_in;
    assign w_diff = {1'b0, i_tdata} - {1'b0, w_off};

    offset_calibrator #(
        .WIDTH    (WIDTH),
        .CAL_LOG2 (CAL_LOG2)
    ) u_cal (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (clear),
        .i_start  (cal_start),
        .i_accept (w_accept),
        .i_data   (i_tdata),
        .o_busy   (cal_busy),
        .o_done   (cal_done),
        .o_offset (cal_offset)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else if (clear) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else if (w_accept) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_diff;
        end else if (o_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign o_tvalid = r_tvalid;
    assign o_tdata  = r_tdata;

endmodule

// File: tb/tb_adc_offset_cutter.sv
// Scoreboard bench for adc_offset_cutter with a queue-based reference model.
module tb_adc_offset_cutter;

    localparam int W     = 14;
    localparam int L     = 2;
    localparam int CAL_N = 1 << L;

    logic         clk = 0;
    logic         reset = 1;
    logic         clear = 0;
    logic [W-1:0] i_tdata = '0;
    logic         i_tvalid = 0;
    logic         i_tready;
    logic [W:0]   o_tdata;
    logic         o_tvalid;
    logic         o_tready = 1;
    logic [W-1:0] offset_in = '0;
    logic         offset_sel = 0;
    logic         cal_start = 0;
    logic         cal_busy;
    logic         cal_done;
    logic [W-1:0] cal_offset;

    adc_offset_cutter #(.WIDTH(W), .CAL_LOG2(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .i_tdata    (i_tdata),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .offset_in  (offset_in),
        .offset_sel (offset_sel),
        .cal_start  (cal_start),
        .cal_busy   (cal_busy),
        .cal_done   (cal_done),
        .cal_offset (cal_offset)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W:0]   exp_q[$];
    int           samples[$];
    logic         m_valid = 0;
    logic         m_cal = 0;
    logic         m_done = 0;
    logic [W-1:0] m_off = '0;
    logic         last_acc = 0;
    logic [W:0]   last_out = '0;
    logic         hold = 0;
    logic [W:0]   hold_data = '0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model evaluated once per cycle, just before the edge.
    task automatic model_step();
        logic         acc;
        logic         rdy;
        logic [W-1:0] off;
        int           sum;
        chk("o_tvalid", int'(o_tvalid), int'(m_valid));
        rdy = !m_valid || o_tready;
        chk("i_tready", int'(i_tready), int'(rdy));
        chk("cal_busy", int'(cal_busy), int'(m_cal));
        chk("cal_done", int'(cal_done), int'(m_done));
        chk("cal_offset", int'(cal_offset), int'(m_off));
        last_acc = 0;
        m_done = 0;
        if (reset) begin
            m_valid = 0;
            m_cal = 0;
            m_off = '0;
            exp_q.delete();
            samples.delete();
            return;
        end
        if (clear) begin
            if (m_valid && !o_tready) exp_q.delete();
            m_valid = 0;
            m_cal = 0;
            samples.delete();
            return;
        end
        acc = i_tvalid && rdy;
        last_acc = acc;
        if (acc) begin
            off = offset_sel ? m_off : offset_in;
            exp_q.push_back((W+1)'(int'(i_tdata) - int'(off)));
        end
        m_valid = acc || (m_valid && !o_tready);
        if (m_cal) begin
            if (acc) begin
                samples.push_back(int'(i_tdata));
                if (samples.size() == CAL_N) begin
                    sum = 0;
                    foreach (samples[k]) sum += samples[k];
                    m_off = W'(sum / CAL_N);
                    m_done = 1;
                    m_cal = 0;
                end
            end
        end else if (cal_start) begin
            m_cal = 1;
            samples.delete();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cal_start = 0;
        clear = 0;
    endtask

    task automatic send(input int d);
        i_tvalid = 1;
        i_tdata = W'(d);
        for (int n = 0; n < 40; n++) begin
            tick();
            if (last_acc) begin
                i_tvalid = 0;
                return;
            end
        end
        i_tvalid = 0;
        chk("send_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (!reset && o_tvalid && hold) begin
            checks++;
            if (o_tdata !== hold_data) begin
                errors++;
                $display("FAIL stable: got %0h expected %0h", o_tdata, hold_data);
            end
        end
        if (!reset && o_tvalid && o_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %0h expected none", o_tdata);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if (o_tdata !== e) begin
                    errors++;
                    $display("FAIL o_tdata: got %0h expected %0h at %0t", o_tdata, e, $time);
                end
            end
            last_out = o_tdata;
        end
        hold = !reset && !clear && o_tvalid && !o_tready;
        hold_data = o_tdata;
    end

    initial begin
        #1;
        tick();
        tick();
        reset = 0;
        tick();
        chk("rst_tdata", int'(o_tdata), 0);

        offset_sel = 0;
        offset_in = 14'd8192;
        send(8200);
        send(8000);
        tick();
        tick();
        chk("neg192", int'(last_out), 'h7F40);

        offset_in = 14'd16383;
        send(0);
        tick();
        chk("min", int'(last_out), 'h4001);
        offset_in = 14'd0;
        send(16383);
        tick();
        chk("max", int'(last_out), 'h3FFF);

        offset_in = 14'd10;
        o_tready = 0;
        send(1000);
        i_tvalid = 1;
        i_tdata = 14'd2000;
        repeat (3) tick();
        o_tready = 1;
        send(2000);
        send(3000);
        repeat (3) tick();

        cal_start = 1;
        tick();
        send(100);
        send(101);
        send(102);
        send(104);
        repeat (2) tick();
        chk("cal101", int'(cal_offset), 101);
        offset_sel = 1;
        send(101);
        tick();
        chk("zero", int'(last_out), 0);

        cal_start = 1;
        tick();
        send(300);
        cal_start = 1;
        send(304);
        send(308);
        send(312);
        repeat (2) tick();
        chk("cal306", int'(cal_offset), 306);

        cal_start = 1;
        tick();
        send(900);
        send(950);
        clear = 1;
        tick();
        repeat (2) tick();
        chk("clr_keep", int'(cal_offset), 306);

        cal_start = 1;
        tick();
        send(500);
        send(600);
        reset = 1;
        tick();
        reset = 0;
        tick();
        chk("rst_off", int'(cal_offset), 0);
        cal_start = 1;
        tick();
        repeat (4) send(200);
        repeat (2) tick();
        chk("cal200", int'(cal_offset), 200);

        for (int c = 0; c < 3000; c++) begin
            i_tvalid = ($urandom_range(3) != 0);
            i_tdata = W'($urandom);
            o_tready = ($urandom_range(3) != 0);
            if ($urandom_range(40) == 0) offset_sel = ~offset_sel;
            if ($urandom_range(40) == 0) offset_in = W'($urandom);
            cal_start = ($urandom_range(15) == 0);
            clear = ($urandom_range(120) == 0);
            reset = ($urandom_range(400) == 0);
            tick();
        end
        reset = 0;
        i_tvalid = 0;
        o_tready = 1;
        repeat (3) tick();
        chk("drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
